// File: rtl/snax_simbacore_launch_pkg.sv
// rtl/snax_simbacore_launch_pkg.sv - shared types and index constants for the SimbaCore CSR launcher
package snax_simbacore_launch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } launch_state_e;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CLR   = 1;

    localparam int unsigned STS_BUSY = 0;
    localparam int unsigned STS_PEND = 1;

    localparam int unsigned RO_STATUS  = 0;
    localparam int unsigned RO_LAUNCH  = 1;
    localparam int unsigned RO_DONE    = 2;
    localparam int unsigned RO_BUSYCYC = 3;

endpackage

// File: rtl/snax_simbacore_event_counter.sv
// rtl/snax_simbacore_event_counter.sv - wrapping event counter with synchronous clear that beats increment
module snax_simbacore_event_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= cnt_o + Width'(1);
        end
    end

endmodule

// File: rtl/snax_simbacore_csr_launcher.sv
// rtl/snax_simbacore_csr_launcher.sv - active/pending job launcher behind the CSR manager; SNAX_SIMBACORE_BUSY_CNT_EN enables the busy-cycle counter
module snax_simbacore_csr_launcher
    import snax_simbacore_launch_pkg::*;
#(
    parameter int unsigned NumRwCsr = 6,
    parameter int unsigned NumRoCsr = 4,
    parameter int unsigned CntWidth = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumRwCsr-1:0][31:0]      csr_reg_rw_set_i,
    input  logic                           csr_reg_set_valid_i,
    output logic                           csr_reg_set_ready_o,
    output logic [NumRoCsr-1:0][31:0]      csr_reg_ro_set_o,
    output logic [NumRwCsr-2:0][31:0]      acc_cfg_o,
    output logic                           acc_start_o,
    input  logic                           acc_done_i
);

    localparam int unsigned NumCfg = NumRwCsr - 1;

    launch_state_e            state_q, state_d;
    logic                     pend_q, pend_d;
    logic                     start_q, start_d;
    logic [NumCfg-1:0][31:0]  act_cfg_q, act_cfg_d;
    logic [NumCfg-1:0][31:0]  pend_cfg_q, pend_cfg_d;

    logic [31:0]              ctrl_word;
    logic [NumCfg-1:0][31:0]  cfg_in;
    logic                     ctrl_start;
    logic                     ctrl_clr;
    logic                     ctrl_unused;
    logic                     accept;
    logic                     done_ok;

    assign ctrl_word   = csr_reg_rw_set_i[NumRwCsr-1];
    assign cfg_in      = csr_reg_rw_set_i[NumCfg-1:0];
    assign ctrl_start  = ctrl_word[CTRL_START];
    assign ctrl_clr    = ctrl_word[CTRL_CLR];
    assign ctrl_unused = ^ctrl_word[31:2];

    assign csr_reg_set_ready_o = !pend_q;
    assign accept              = csr_reg_set_valid_i && !pend_q;
    // A done arriving while our own start is still on the wire belongs to nothing we launched.
    assign done_ok             = acc_done_i && (state_q == BUSY) && !start_q;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        start_d    = 1'b0;
        act_cfg_d  = act_cfg_q;
        pend_cfg_d = pend_cfg_q;
        case (state_q)
            IDLE: begin
                if (accept && ctrl_start) begin
                    act_cfg_d = cfg_in;
                    start_d   = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (done_ok) begin
                    if (pend_q) begin
                        act_cfg_d = pend_cfg_q;
                        pend_d    = 1'b0;
                        start_d   = 1'b1;
                    end else if (accept && ctrl_start) begin
                        // Completion and a new job in the same cycle: launch directly, skip the pending slot.
                        act_cfg_d = cfg_in;
                        start_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept && ctrl_start) begin
                    pend_cfg_d = cfg_in;
                    pend_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            start_q    <= 1'b0;
            act_cfg_q  <= '0;
            pend_cfg_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            start_q    <= start_d;
            act_cfg_q  <= act_cfg_d;
            pend_cfg_q <= pend_cfg_d;
        end
    end

    assign acc_start_o = start_q;
    assign acc_cfg_o   = act_cfg_q;

    logic                cnt_clr;
    logic [CntWidth-1:0] launch_cnt;
    logic [CntWidth-1:0] done_cnt;
    logic [CntWidth-1:0] busy_cnt;

    assign cnt_clr = accept && ctrl_clr;

    snax_simbacore_event_counter #(.Width(CntWidth)) u_launch_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (start_q),
        .cnt_o (launch_cnt)
    );

    snax_simbacore_event_counter #(.Width(CntWidth)) u_done_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (done_ok),
        .cnt_o (done_cnt)
    );

`ifdef SNAX_SIMBACORE_BUSY_CNT_EN
    snax_simbacore_event_counter #(.Width(CntWidth)) u_busy_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (state_q == BUSY),
        .cnt_o (busy_cnt)
    );
`else
    assign busy_cnt = '0;
`endif

    always_comb begin
        csr_reg_ro_set_o                          = '0;
        csr_reg_ro_set_o[RO_STATUS][STS_BUSY]     = (state_q == BUSY);
        csr_reg_ro_set_o[RO_STATUS][STS_PEND]     = pend_q;
        csr_reg_ro_set_o[RO_LAUNCH]               = 32'(launch_cnt);
        csr_reg_ro_set_o[RO_DONE]                 = 32'(done_cnt);
        csr_reg_ro_set_o[RO_BUSYCYC]              = 32'(busy_cnt);
    end

endmodule

// File: tb/tb_snax_simbacore_csr_launcher.sv
// tb/tb_snax_simbacore_csr_launcher.sv - directed scoreboard bench for the SimbaCore CSR launcher
module tb_snax_simbacore_csr_launcher;

    localparam int unsigned NumRwCsr = 6;
    localparam int unsigned NumRoCsr = 5;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NumRwCsr-1:0][31:0] rw_set = '0;
    logic                      valid = 1'b0;
    logic                      ready;
    logic [NumRoCsr-1:0][31:0] ro;
    logic [NumRwCsr-2:0][31:0] cfg;
    logic                      start;
    logic                      done = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

`ifdef SNAX_SIMBACORE_BUSY_CNT_EN
    localparam logic [31:0] ExpBusy10 = 32'd10;
`else
    localparam logic [31:0] ExpBusy10 = 32'd0;
`endif

    always #5 clk = ~clk;

    snax_simbacore_csr_launcher #(
        .NumRwCsr (NumRwCsr),
        .NumRoCsr (NumRoCsr),
        .CntWidth (32)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .csr_reg_rw_set_i    (rw_set),
        .csr_reg_set_valid_i (valid),
        .csr_reg_set_ready_o (ready),
        .csr_reg_ro_set_o    (ro),
        .acc_cfg_o           (cfg),
        .acc_start_o         (start),
        .acc_done_i          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every start pulse must carry the config the bench queued for it.
    always @(negedge clk) begin
        if (!rst && start === 1'b1) begin
            if (exp_q.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
            else                   chk("start_cfg", cfg[0], exp_q.pop_front());
        end
    end

    task automatic send(input logic [31:0] cfg0, input logic [31:0] ctrl, input logic with_done);
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("ready_timeout", {31'd0, ready}, 32'd1);
        rw_set    = '0;
        rw_set[0] = cfg0;
        rw_set[NumRwCsr-1] = ctrl;
        valid = 1'b1;
        done  = with_done;
        @(posedge clk); #1;
        valid = 1'b0;
        done  = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_cfg0", cfg[0], 32'd0);
        for (int i = 0; i < NumRoCsr; i++) chk($sformatf("rst_ro%0d", i), ro[i], 32'd0);

        // first launch from IDLE
        exp_q.push_back(32'h11);
        send(32'h11, 32'h1, 1'b0);
        @(negedge clk);
        chk("l1_start", {31'd0, start}, 32'd1);
        chk("l1_status", ro[0], 32'h1);
        @(negedge clk);
        chk("l1_start_single", {31'd0, start}, 32'd0);
        chk("l1_launch_cnt", ro[1], 32'd1);

        // queue into pending, then done promotes it
        send(32'h22, 32'h1, 1'b0);
        @(negedge clk);
        chk("pend_ready", {31'd0, ready}, 32'd0);
        chk("pend_status", ro[0], 32'h3);
        exp_q.push_back(32'h22);
        pulse_done();
        @(negedge clk);
        chk("promo_start", {31'd0, start}, 32'd1);
        chk("promo_cfg", cfg[0], 32'h22);
        chk("promo_ready", {31'd0, ready}, 32'd1);
        chk("promo_done_cnt", ro[2], 32'd1);
        @(negedge clk);
        chk("promo_launch_cnt", ro[1], 32'd2);

        // done and START accept in the same cycle, nothing pending
        exp_q.push_back(32'h33);
        send(32'h33, 32'h1, 1'b1);
        @(negedge clk);
        chk("direct_start", {31'd0, start}, 32'd1);
        chk("direct_status", ro[0], 32'h1);
        chk("direct_ready", {31'd0, ready}, 32'd1);
        chk("direct_done_cnt", ro[2], 32'd2);

        // done during the start cycle is ignored
        pulse_done();
        @(negedge clk);
        chk("ign_done_cnt", ro[2], 32'd2);
        chk("ign_status", ro[0], 32'h1);
        chk("ign_launch_cnt", ro[1], 32'd3);
        pulse_done();
        @(negedge clk);
        chk("idle_status", ro[0], 32'h0);
        chk("idle_done_cnt", ro[2], 32'd3);

        // START=0 transaction with CLR_CNT
        send(32'h99, 32'h2, 1'b0);
        @(negedge clk);
        chk("clr_start", {31'd0, start}, 32'd0);
        chk("clr_launch_cnt", ro[1], 32'd0);
        chk("clr_done_cnt", ro[2], 32'd0);
        chk("clr_busy_cnt", ro[3], 32'd0);
        chk("clr_status", ro[0], 32'h0);
        chk("clr_cfg_kept", cfg[0], 32'h33);

        // ten cycles in BUSY
        exp_q.push_back(32'h44);
        send(32'h44, 32'h1, 1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        pulse_done();
        @(negedge clk);
        chk("busy_cnt10", ro[3], ExpBusy10);
        chk("busy_status", ro[0], 32'h0);
        chk("busy_done_cnt", ro[2], 32'd1);
        chk("busy_launch_cnt", ro[1], 32'd1);
        chk("ro4_zero", ro[4], 32'd0);

        // reset mid-job with pending set
        exp_q.push_back(32'h55);
        send(32'h55, 32'h1, 1'b0);
        send(32'h66, 32'h1, 1'b0);
        @(negedge clk);
        chk("pre_rst_status", ro[0], 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("arst_start", {31'd0, start}, 32'd0);
        chk("arst_cfg0", cfg[0], 32'd0);
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_status", ro[0], 32'h0);
        chk("arst_launch_cnt", ro[1], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_done();
        @(negedge clk);
        chk("spur_done_cnt", ro[2], 32'd0);
        chk("spur_status", ro[0], 32'h0);
        chk("spur_start", {31'd0, start}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
